// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter
// Round-robin arbiter that shares one AXI stream output between NUM_PORTS
// sources. The arbiter grants whole packets: the winner keeps the output from
// its first beat until the tlast beat is accepted. Nothing is buffered, so the
// selected source is wired straight through to the output.

module axis_packet_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int AXIS_DATA_WIDTH = 32
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_PORTS-1:0]                 i_enable,
   input  logic [NUM_PORTS-1:0]                 i_axis_in_tuser,
   input  logic [NUM_PORTS-1:0]                 i_axis_in_tvalid,
   output logic [NUM_PORTS-1:0]                 o_axis_in_tready,
   input  logic [NUM_PORTS-1:0]                 i_axis_in_tlast,
   input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] i_axis_in_tdata,
   output logic                                 o_axis_out_tuser,
   output logic                                 o_axis_out_tvalid,
   input  logic                                 i_axis_out_tready,
   output logic                                 o_axis_out_tlast,
   output logic [AXIS_DATA_WIDTH-1:0]           o_axis_out_tdata,
   output logic [NUM_PORTS-1:0]                 o_grant,
   output logic                                 o_busy,
   output logic [31:0]                          o_pkt_count
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [PTR_W-1:0]     owner_q, owner_d;
   logic [PTR_W-1:0]     lastServed_q, lastServed_d;
   logic [31:0]          pktCount_q, pktCount_d;

   logic [NUM_PORTS-1:0] req;
   logic                 reqFound;
   logic [PTR_W-1:0]     winner;
   logic [PTR_W-1:0]     candIdx;
   logic                 beatXfer;

   // Round-robin search: first enabled requester after the last-served port, wrapping around.
   always_comb begin
      req      = i_axis_in_tvalid & i_enable;
      reqFound = 1'b0;
      winner   = '0;
      candIdx  = '0;
      for (int i = 1; i <= NUM_PORTS; i++) begin
         candIdx = PTR_W'((int'(lastServed_q) + i) % NUM_PORTS);
         if (!reqFound && req[candIdx]) begin
            reqFound = 1'b1;
            winner   = candIdx;
         end
      end
   end

   // Zero-latency mux from the granted source to the output; everything is quiet without a grant.
   always_comb begin
      o_axis_out_tvalid = 1'b0;
      o_axis_out_tuser  = 1'b0;
      o_axis_out_tlast  = 1'b0;
      o_axis_out_tdata  = '0;
      o_axis_in_tready  = '0;
      if (state_q == GRANT) begin
         o_axis_out_tvalid         = i_axis_in_tvalid[owner_q];
         o_axis_out_tuser          = i_axis_in_tuser[owner_q];
         o_axis_out_tlast          = i_axis_in_tlast[owner_q];
         o_axis_out_tdata          = i_axis_in_tdata[int'(owner_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
         o_axis_in_tready[owner_q] = i_axis_out_tready;
      end
   end

   assign beatXfer = o_axis_out_tvalid & i_axis_out_tready;

   // Next-state logic: arbitrate in IDLE, hold the grant until the tlast beat is accepted.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      lastServed_d = lastServed_q;
      pktCount_d   = pktCount_q;
      unique case (state_q)
         IDLE: begin
            if (reqFound) begin
               state_d = GRANT;
               grant_d = NUM_PORTS'(1) << winner;
               owner_d = winner;
            end
         end
         GRANT: begin
            if (beatXfer && o_axis_out_tlast) begin
               state_d      = IDLE;
               grant_d      = '0;
               lastServed_d = owner_q;
               pktCount_d   = pktCount_q + 32'd1;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State registers; reset hands port 0 first priority by pointing last-served at the top port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         lastServed_q <= PTR_W'(NUM_PORTS - 1);
         pktCount_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         lastServed_q <= lastServed_d;
         pktCount_q   <= pktCount_d;
      end
   end

   assign o_grant     = grant_q;
   assign o_busy      = (state_q == GRANT);
   assign o_pkt_count = pktCount_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter
// Per-port packet sources feed the arbiter; every beat expected on the output
// is queued in service order and checked when the output accepts it.

module tb_axis_packet_arbiter;

   localparam int NP = 4;
   localparam int W  = 32;

   logic              clk;
   logic              rst;
   logic [NP-1:0]     enable;
   logic [NP-1:0]     inUser;
   logic [NP-1:0]     inValid;
   logic [NP-1:0]     inReady;
   logic [NP-1:0]     inLast;
   logic [NP*W-1:0]   inData;
   logic              outUser;
   logic              outValid;
   logic              outReady;
   logic              outLast;
   logic [W-1:0]      outData;
   logic [NP-1:0]     grant;
   logic              busy;
   logic [31:0]       pktCount;

   typedef struct {
      int         port;
      logic [W-1:0] data;
      logic       last;
      logic       user;
   } exp_t;

   exp_t         expQ[$];
   logic [W-1:0] srcData [NP][64];
   logic         srcLast [NP][64];
   int           srcHead [NP];
   int           srcTail [NP];
   logic [NP-1:0] fired;

   int compared   = 0;
   int mismatched = 0;

   axis_packet_arbiter #(
      .NUM_PORTS      (NP),
      .AXIS_DATA_WIDTH(W)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_enable         (enable),
      .i_axis_in_tuser  (inUser),
      .i_axis_in_tvalid (inValid),
      .o_axis_in_tready (inReady),
      .i_axis_in_tlast  (inLast),
      .i_axis_in_tdata  (inData),
      .o_axis_out_tuser (outUser),
      .o_axis_out_tvalid(outValid),
      .i_axis_out_tready(outReady),
      .o_axis_out_tlast (outLast),
      .o_axis_out_tdata (outData),
      .o_grant          (grant),
      .o_busy           (busy),
      .o_pkt_count      (pktCount)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present the head beat of every source queue on its input port
   task automatic driveInputs();
      for (int p = 0; p < NP; p++) begin
         if (srcHead[p] < srcTail[p]) begin
            inValid[p]         = 1'b1;
            inLast[p]          = srcLast[p][srcHead[p]];
            inData[p*W +: W]   = srcData[p][srcHead[p]];
            inUser[p]          = srcData[p][srcHead[p]][0];
         end else begin
            inValid[p]         = 1'b0;
            inLast[p]          = 1'b0;
            inData[p*W +: W]   = '0;
            inUser[p]          = 1'b0;
         end
      end
   endtask

   task automatic flushSources();
      for (int p = 0; p < NP; p++) begin
         srcHead[p] = 0;
         srcTail[p] = 0;
      end
      expQ.delete();
      driveInputs();
   endtask

   // Queue a packet on one source; the first expN beats are expected at the output
   task automatic loadPacket(input int port, input int n, input logic [W-1:0] base, input int expN);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         srcData[port][srcTail[port]] = base + W'(i);
         srcLast[port][srcTail[port]] = (i == n - 1);
         srcTail[port]++;
         if (i < expN) begin
            e.port = port;
            e.data = base + W'(i);
            e.last = (i == n - 1);
            e.user = e.data[0];
            expQ.push_back(e);
         end
      end
      driveInputs();
   endtask

   function automatic bit anyPending();
      bit r = 1'b0;
      for (int p = 0; p < NP; p++)
         if (srcHead[p] < srcTail[p]) r = 1'b1;
      return r;
   endfunction

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Source side: retire beats that were accepted at the last edge
   initial begin
      forever begin
         @(negedge clk);
         fired = inValid & inReady;
         @(posedge clk);
         #1;
         for (int p = 0; p < NP; p++)
            if (fired[p]) srcHead[p]++;
         driveInputs();
      end
   end

   // Output side: every accepted beat must match the head of the expectation queue
   initial begin
      exp_t          e;
      logic [NP-1:0] expGrant;
      forever begin
         @(negedge clk);
         if (outValid && outReady) begin
            compared++;
            if (expQ.size() == 0) begin
               mismatched++;
               $display("[TB] FAIL beat_unexpected: got data=%h grant=%b, required no beat", outData, grant);
            end else begin
               e = expQ.pop_front();
               expGrant = NP'(1) << e.port;
               if ({grant, outData, outLast, outUser} !== {expGrant, e.data, e.last, e.user}) begin
                  mismatched++;
                  $display("[TB] FAIL beat: got grant=%b data=%h last=%b user=%b, required grant=%b data=%h last=%b user=%b",
                           grant, outData, outLast, outUser, expGrant, e.data, e.last, e.user);
               end
            end
         end
      end
   end

   // Wait until every queued beat has gone through and the arbiter is idle
   task automatic waitDrain(input string name, input int maxCycles);
      int n = 0;
      while ((expQ.size() != 0 || busy || anyPending()) && n < maxCycles) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (n >= maxCycles) begin
         mismatched++;
         $display("[TB] FAIL %s_drain: got %0d beats outstanding after %0d cycles, required 0", name, expQ.size(), n);
      end
   endtask

   task automatic applyReset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      flushSources();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      enable   = '1;
      outReady = 1'b1;
      flushSources();
      loadPacket(0, 2, 32'h11, 0);
      repeat (3) @(negedge clk);
      compared++;
      if ({inReady, outValid, outData, outLast, outUser, grant, busy} !== '0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs: got tready=%b tvalid=%b data=%h grant=%b busy=%b, required all 0",
                  inReady, outValid, outData, grant, busy);
      end
      compared++;
      if (pktCount !== 32'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_count: got %0d, required 0", pktCount);
      end
      flushSources();
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic test_single_port();
      nextCycle();
      loadPacket(1, 4, 32'hA0, 4);
      @(negedge clk);
      compared++;
      if (grant !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL single_arb_cycle: got grant=%b, required 0000", grant);
      end
      @(negedge clk);
      compared++;
      if (grant !== 4'b0010) begin
         mismatched++;
         $display("[TB] FAIL single_grant: got grant=%b, required 0010", grant);
      end
      repeat (3) @(negedge clk);
      compared++;
      if ({outData, outLast} !== {32'hA3, 1'b1}) begin
         mismatched++;
         $display("[TB] FAIL single_last_beat: got data=%h last=%b, required data=000000a3 last=1", outData, outLast);
      end
      @(negedge clk);
      compared++;
      if ({busy, pktCount} !== {1'b0, 32'd1}) begin
         mismatched++;
         $display("[TB] FAIL single_done: got busy=%b count=%0d, required busy=0 count=1", busy, pktCount);
      end
      waitDrain("single", 20);
   endtask

   task automatic test_round_robin();
      int n;
      applyReset();
      nextCycle();
      for (int k = 0; k < 2; k++) begin
         loadPacket(0, 2, 32'h100 + 32'(k * 16), 2);
         loadPacket(2, 2, 32'h200 + 32'(k * 16), 2);
         loadPacket(3, 2, 32'h300 + 32'(k * 16), 2);
      end
      n = 0;
      while (pktCount != 32'd6 && n < 100) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (n != 19) begin
         mismatched++;
         $display("[TB] FAIL rr_cycles: got 6 packets by cycle %0d, required cycle 19", n);
      end
      waitDrain("rr", 20);
   endtask

   task automatic test_enable_mask();
      logic [31:0] base;
      base = pktCount;
      nextCycle();
      enable = 4'b1101;
      loadPacket(3, 2, 32'hC0, 2);
      loadPacket(1, 2, 32'hB0, 2);
      repeat (2) @(negedge clk);
      compared++;
      if ({grant, inReady[1]} !== {4'b1000, 1'b0}) begin
         mismatched++;
         $display("[TB] FAIL mask_grant: got grant=%b tready1=%b, required grant=1000 tready1=0", grant, inReady[1]);
      end
      repeat (4) @(negedge clk);
      compared++;
      if ({grant, inReady[1], pktCount} !== {4'b0000, 1'b0, base + 32'd1}) begin
         mismatched++;
         $display("[TB] FAIL mask_skip: got grant=%b tready1=%b count=%0d, required grant=0000 tready1=0 count=%0d",
                  grant, inReady[1], pktCount, base + 32'd1);
      end
      nextCycle();
      enable = 4'b1111;
      repeat (2) @(negedge clk);
      compared++;
      if (grant !== 4'b0010) begin
         mismatched++;
         $display("[TB] FAIL mask_reenable: got grant=%b, required 0010", grant);
      end
      waitDrain("mask", 20);
   endtask

   task automatic test_backpressure();
      applyReset();
      nextCycle();
      loadPacket(0, 3, 32'hD0, 3);
      loadPacket(2, 1, 32'hE0, 1);
      nextCycle();
      nextCycle();
      outReady = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         compared++;
         if ({outValid, outData, inReady, grant} !== {1'b1, 32'hD1, 4'b0000, 4'b0001}) begin
            mismatched++;
            $display("[TB] FAIL bp_hold: got valid=%b data=%h tready=%b grant=%b, required valid=1 data=000000d1 tready=0000 grant=0001",
                     outValid, outData, inReady, grant);
         end
      end
      nextCycle();
      outReady = 1'b1;
      waitDrain("bp", 30);
   endtask

   task automatic test_reset_mid_packet();
      nextCycle();
      loadPacket(2, 4, 32'hF0, 1);
      nextCycle();
      nextCycle();
      rst = 1'b1;
      #1;
      compared++;
      if ({inReady, outValid, grant, pktCount} !== {4'b0000, 1'b0, 4'b0000, 32'd0}) begin
         mismatched++;
         $display("[TB] FAIL rst_mid: got tready=%b valid=%b grant=%b count=%0d, required all 0",
                  inReady, outValid, grant, pktCount);
      end
      flushSources();
      nextCycle();
      rst = 1'b0;
      nextCycle();
      loadPacket(0, 2, 32'h40, 2);
      loadPacket(2, 2, 32'h50, 2);
      repeat (2) @(negedge clk);
      compared++;
      if (grant !== 4'b0001) begin
         mismatched++;
         $display("[TB] FAIL rst_priority: got grant=%b, required 0001", grant);
      end
      waitDrain("rst", 20);
   endtask

   task automatic test_count_wrap();
      @(negedge clk);
      force dut.pktCount_q = 32'hFFFF_FFFF;
      nextCycle();
      release dut.pktCount_q;
      loadPacket(1, 1, 32'h60, 1);
      loadPacket(1, 1, 32'h61, 1);
      @(negedge clk);
      compared++;
      if (pktCount !== 32'hFFFF_FFFF) begin
         mismatched++;
         $display("[TB] FAIL wrap_preset: got %h, required ffffffff", pktCount);
      end
      @(negedge clk);
      compared++;
      if ({grant, outLast} !== {4'b0010, 1'b1}) begin
         mismatched++;
         $display("[TB] FAIL wrap_single_beat: got grant=%b last=%b, required grant=0010 last=1", grant, outLast);
      end
      @(negedge clk);
      compared++;
      if ({grant, pktCount} !== {4'b0000, 32'd0}) begin
         mismatched++;
         $display("[TB] FAIL wrap_count: got grant=%b count=%h, required grant=0000 count=00000000", grant, pktCount);
      end
      @(negedge clk);
      compared++;
      if (grant !== 4'b0010) begin
         mismatched++;
         $display("[TB] FAIL wrap_regrant: got grant=%b, required 0010", grant);
      end
      @(negedge clk);
      compared++;
      if ({busy, pktCount} !== {1'b0, 32'd1}) begin
         mismatched++;
         $display("[TB] FAIL wrap_after: got busy=%b count=%0d, required busy=0 count=1", busy, pktCount);
      end
      waitDrain("wrap", 20);
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_single_port();
      test_round_robin();
      test_enable_mask();
      test_backpressure();
      test_reset_mid_packet();
      test_count_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion by 200000, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
